// File: rtl/l2_ctrl_regs_if.sv
// Port bundle between the L2 FSM and its control/status register bank.
// slave: register bank side (triggers in, state out); master: L2 FSM side.
// Widths derive from the same parameters as the register bank.
interface l2_ctrl_regs_if #(
  parameter int N_MSHR  = 8,
  parameter int N_FLAGS = 5,
  parameter int N_FWD   = 2,
  parameter int L2_SETS = 256,
  parameter int L2_WAYS = 8
);
  localparam int MB = $clog2(N_MSHR);
  localparam int CB = $clog2(N_MSHR + 1);
  localparam int FB = (N_FWD > 1) ? $clog2(N_FWD) : 1;
  localparam int SB = $clog2(L2_SETS);
  localparam int WB = $clog2(L2_WAYS);

  // MSHR credits
  logic          mshr_alloc;
  logic          mshr_free;
  logic [CB-1:0] mshr_cnt;
  logic          mshr_none_free;
  logic          mshr_all_free;
  logic          err_underflow;
  logic          err_overflow;
  // stall flags
  logic [N_FLAGS-1:0] flag_set;
  logic [N_FLAGS-1:0] flag_clr;
  logic [N_FLAGS-1:0] flags;
  // forward-stall tracker
  logic          fwd_alloc;
  logic [MB-1:0] fwd_alloc_entry;
  logic          fwd_alloc_ready;
  logic          mshr_clr_valid;
  logic [MB-1:0] mshr_clr_idx;
  logic          fwd_release;
  logic [FB-1:0] fwd_release_slot;
  logic          fwd_stall;
  logic          fwd_stall_ended;
  logic [FB-1:0] fwd_ended_slot;
  logic [MB-1:0] fwd_ended_entry;
  // flush walker
  logic          flush_start;
  logic          flush_step;
  logic          flush_abort;
  logic          ongoing_flush;
  logic [SB-1:0] flush_set;
  logic [WB-1:0] flush_way;
  logic          flush_done;

  modport slave (
    input  mshr_alloc, mshr_free, flag_set, flag_clr,
           fwd_alloc, fwd_alloc_entry, mshr_clr_valid, mshr_clr_idx,
           fwd_release, fwd_release_slot, flush_start, flush_step, flush_abort,
    output mshr_cnt, mshr_none_free, mshr_all_free, err_underflow, err_overflow,
           flags, fwd_alloc_ready, fwd_stall, fwd_stall_ended, fwd_ended_slot,
           fwd_ended_entry, ongoing_flush, flush_set, flush_way, flush_done
  );

  modport master (
    output mshr_alloc, mshr_free, flag_set, flag_clr,
           fwd_alloc, fwd_alloc_entry, mshr_clr_valid, mshr_clr_idx,
           fwd_release, fwd_release_slot, flush_start, flush_step, flush_abort,
    input  mshr_cnt, mshr_none_free, mshr_all_free, err_underflow, err_overflow,
           flags, fwd_alloc_ready, fwd_stall, fwd_stall_ended, fwd_ended_slot,
           fwd_ended_entry, ongoing_flush, flush_set, flush_way, flush_done
  );
endinterface

// File: rtl/l2_ctrl_regs.sv
// L2 controller register bank: MSHR credit counter, stall flags, forward-stall tracker, flush walker.
// Ports: clk, rst (async active-low), bus (l2_ctrl_regs_if.slave) carrying all triggers and status.
// State updates one cycle after its trigger; derived status is combinational from registered state.
module l2_ctrl_regs #(
  parameter int N_MSHR  = 8,
  parameter int N_FLAGS = 5,
  parameter int N_FWD   = 2,
  parameter int L2_SETS = 256,
  parameter int L2_WAYS = 8
) (
  input logic            clk,
  input logic            rst,
  l2_ctrl_regs_if.slave  bus
);
  localparam int MB = $clog2(N_MSHR);
  localparam int CB = $clog2(N_MSHR + 1);
  localparam int FB = (N_FWD > 1) ? $clog2(N_FWD) : 1;
  localparam int SB = $clog2(L2_SETS);
  localparam int WB = $clog2(L2_WAYS);

  // ---------------- MSHR credit counter ----------------
  logic [CB-1:0] cnt;
  logic          err_under;
  logic          err_over;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= CB'(N_MSHR);
      err_under <= 1'b0;
      err_over  <= 1'b0;
    end else if (bus.mshr_alloc && !bus.mshr_free) begin
      if (cnt == '0) err_under <= 1'b1;
      else           cnt       <= cnt - 1'b1;
    end else if (bus.mshr_free && !bus.mshr_alloc) begin
      if (cnt == CB'(N_MSHR)) err_over <= 1'b1;
      else                    cnt      <= cnt + 1'b1;
    end
  end

  assign bus.mshr_cnt       = cnt;
  assign bus.mshr_none_free = (cnt == '0);
  assign bus.mshr_all_free  = (cnt == CB'(N_MSHR));
  assign bus.err_underflow  = err_under;
  assign bus.err_overflow   = err_over;

  // ---------------- stall flags (clear wins) ----------------
  logic [N_FLAGS-1:0] flag_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flag_q <= '0;
    else      flag_q <= (flag_q | bus.flag_set) & ~bus.flag_clr;
  end

  assign bus.flags = flag_q;

  // ---------------- forward-stall tracker ----------------
  logic [N_FWD-1:0] slot_vld;
  logic [N_FWD-1:0] slot_ended;
  logic [MB-1:0]    slot_entry [N_FWD];
  logic [FB-1:0]    free_slot;
  logic [FB-1:0]    ended_slot;
  logic             alloc_go;

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    free_slot  = '0;
    ended_slot = '0;
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (!slot_vld[i])                 free_slot  = FB'(i);
      if (slot_vld[i] && slot_ended[i]) ended_slot = FB'(i);
    end
  end

  // Ready looks only at registered valids, so a slot released this cycle is not reusable yet.
  assign alloc_go = bus.fwd_alloc && bus.fwd_alloc_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_vld   <= '0;
      slot_ended <= '0;
      for (int i = 0; i < N_FWD; i++) slot_entry[i] <= '0;
    end else begin
      for (int i = 0; i < N_FWD; i++) begin
        if (alloc_go && free_slot == FB'(i)) begin
          // A retire of the same entry in the allocation cycle must not be lost.
          slot_vld[i]   <= 1'b1;
          slot_entry[i] <= bus.fwd_alloc_entry;
          slot_ended[i] <= bus.mshr_clr_valid && (bus.fwd_alloc_entry == bus.mshr_clr_idx);
        end else if (bus.fwd_release && bus.fwd_release_slot == FB'(i)) begin
          slot_vld[i]   <= 1'b0;
          slot_ended[i] <= 1'b0;
        end else if (slot_vld[i] && bus.mshr_clr_valid && slot_entry[i] == bus.mshr_clr_idx) begin
          slot_ended[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.fwd_alloc_ready = ~&slot_vld;
  assign bus.fwd_stall       = |slot_vld;
  assign bus.fwd_stall_ended = |(slot_vld & slot_ended);
  assign bus.fwd_ended_slot  = ended_slot;
  assign bus.fwd_ended_entry = slot_entry[ended_slot];

  // ---------------- flush walker ----------------
  typedef enum logic {IDLE, WALK} flush_state_e;
  flush_state_e  state;
  logic [SB-1:0] set_q;
  logic [WB-1:0] way_q;
  logic          done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      set_q  <= '0;
      way_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.flush_start) begin
            state <= WALK;
            set_q <= '0;
            way_q <= '0;
          end
        end
        WALK: begin
          if (bus.flush_abort) begin
            state <= IDLE;
            set_q <= '0;
            way_q <= '0;
          end else if (bus.flush_step) begin
            if (way_q == WB'(L2_WAYS - 1)) begin
              way_q <= '0;
              if (set_q == SB'(L2_SETS - 1)) begin
                state  <= IDLE;
                set_q  <= '0;
                done_q <= 1'b1;
              end else begin
                set_q <= set_q + 1'b1;
              end
            end else begin
              way_q <= way_q + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ongoing_flush = (state == WALK);
  assign bus.flush_set     = set_q;
  assign bus.flush_way     = way_q;
  assign bus.flush_done    = done_q;
endmodule
